// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

    // Arbiter FSM: IDLE = nobody owns the write port, GRANT = one requester does.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_BURST_LEN = 4;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: the first set bit of valid, scanning upward from
// last_idx+1 and wrapping, so last_idx itself has the lowest priority.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     last_idx,
    output logic               found,
    output logic [IDW-1:0]     index
);

    // Walk all NUM_REQ positions after last_idx; the first hit wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && valid[(int'(last_idx) + k) % NUM_REQ]) begin
                found = 1'b1;
                index = IDW'((int'(last_idx) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one requester at a time the write port of an
// external FIFO, for at most BURST_LEN words or until the packet ends.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wen,
    output logic signed [DATA_WIDTH-1:0]  fifo_din,
    input  logic                          fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_t     state;
    logic [3:0]     burst_cnt;
    logic [3:0]     burst_cnt_inc;
    logic [IDW-1:0] last_grant;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic           xfer;
    logic           burst_done;
    logic           release_grant;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_picker (
        .valid    (req_valid),
        .last_idx (last_grant),
        .found    (pick_found),
        .index    (pick_idx)
    );

    // Accept only from the grantee; rst/clear suppress a coincident transfer
    // so the requester never sees a handshake for a word that was not written.
    always_comb begin
        req_ready = '0;
        if (state == GRANT && !rst && !clear)
            req_ready[grant_id] = !fifo_full;
    end

    assign xfer          = req_valid[grant_id] && req_ready[grant_id];
    assign burst_cnt_inc = burst_cnt + 4'd1;
    assign burst_done    = (burst_cnt_inc == 4'(BURST_LEN));
    assign release_grant = xfer && (req_last[grant_id] || burst_done);
    assign fifo_wen      = xfer;

    // Zero-latency write path; data is held at zero when nothing is written.
    always_comb begin
        fifo_din = '0;
        if (xfer)
            fifo_din = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Arbitration FSM: pick in IDLE, count transfers in GRANT, release on
    // packet end or full burst, and always pass through IDLE between grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
            grant_id   <= '0;
            busy       <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= GRANT;
                        grant_id  <= pick_idx;
                        burst_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        state      <= IDLE;
                        last_grant <= grant_id;
                        burst_cnt  <= '0;
                        busy       <= 1'b0;
                    end else if (xfer) begin
                        burst_cnt <= burst_cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
